// File: rtl/collision_resolver.sv
// Tile-map collision resolver: moves an entity box by its net velocity, probes the
// leading edge per axis (X then Y) and clamps against solid tiles. Optional COLLISION_SCROLL_EN.
module collision_resolver #(
    parameter int TILE_LOG2 = 4,
    parameter int MAP_COLS  = 40,
    parameter int MAP_ROWS  = 30,
    parameter int SPR_W     = 16,
    parameter int SPR_H     = 16,
    parameter int V_W       = 6,
    parameter int DATA_W    = 5
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [9:0]        X_Pos,
    input  logic [9:0]        Y_Pos,
    input  logic [V_W-1:0]    Right_V,
    input  logic [V_W-1:0]    Left_V,
    input  logic [V_W-1:0]    Up_V,
    input  logic [V_W-1:0]    Down_V,
`ifdef COLLISION_SCROLL_EN
    input  logic [11:0]       scroll_x,
`endif
    output logic [10:0]       map_addr,
    input  logic [DATA_W-1:0] map_data,
    output logic [9:0]        X_Out,
    output logic [9:0]        Y_Out,
    output logic              hit_left,
    output logic              hit_right,
    output logic              hit_up,
    output logic              hit_down
);
    localparam int CW = 16;
    localparam int PX = SPR_H / (2 ** TILE_LOG2) + 1;
    localparam int PY = SPR_W / (2 ** TILE_LOG2) + 1;
    localparam logic [7:0]     PX_END  = 8'(PX);
    localparam logic [7:0]     PY_END  = 8'(PY);
    localparam logic [7:0]     PX_LAST = 8'(PX - 1);
    localparam logic [7:0]     PY_LAST = 8'(PY - 1);
    localparam logic [V_W-1:0] VMAX    = V_W'((1 << TILE_LOG2) - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_NETV   = 3'd1;
    localparam logic [2:0] S_XPROBE = 3'd2;
    localparam logic [2:0] S_XRES   = 3'd3;
    localparam logic [2:0] S_YPROBE = 3'd4;
    localparam logic [2:0] S_YRES   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]           r_state, w_state_nxt;
    logic [7:0]           r_cnt, w_k;
    logic signed [CW-1:0] r_xn, r_yn;
    logic [9:0]           r_y;
    logic                 r_xmove, r_xpos, r_ymove, r_ypos;
    logic                 r_solid, r_oob_cur, r_oob_prv;
    logic signed [CW-1:0] w_scroll, w_wx, w_xlead, w_ylead;
    logic signed [CW-1:0] w_x_res, w_y_res, w_xsrc;
    logic signed [CW-1:0] w_lead, w_base, w_last, w_idx, w_row, w_col;
    logic signed [31:0]   w_lin;
    logic                 w_hl, w_hr, w_hu, w_hd, w_oob, w_load, w_probe;
    logic                 w_unused;

    // Position moved by the clamped net speed (positive direction minus negative one).
    function automatic logic signed [CW-1:0] f_move(input logic [9:0] pos,
                                                    input logic [V_W-1:0] v_pos,
                                                    input logic [V_W-1:0] v_neg);
        logic [V_W-1:0]       mag;
        logic signed [CW-1:0] base;
        base = signed'(CW'(pos));
        if (v_pos >= v_neg) mag = v_pos - v_neg;
        else                mag = v_neg - v_pos;
        if (mag > VMAX) mag = VMAX;
        else            mag = mag;
        if (v_pos >= v_neg) f_move = base + signed'(CW'(mag));
        else                f_move = base - signed'(CW'(mag));
    endfunction

`ifdef COLLISION_SCROLL_EN
    logic [11:0] r_scroll;
    // Scroll offset captured with the request.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)                       r_scroll <= 12'd0;
        else if (r_state == S_IDLE && start) r_scroll <= scroll_x;
        else                                r_scroll <= r_scroll;
    end
    assign w_scroll = signed'(CW'(r_scroll));
`else
    assign w_scroll = {CW{1'b0}};
`endif

    assign w_probe = (r_state == S_XPROBE) || (r_state == S_YPROBE);
    assign w_load  = (r_state == S_NETV   && r_xmove) || (r_state == S_XPROBE && r_cnt < PX_LAST) ||
                     (r_state == S_XRES   && r_ymove) || (r_state == S_YPROBE && r_cnt < PY_LAST);
    assign w_wx    = r_xn + w_scroll;
    assign w_xlead = r_xpos ? ((w_wx + CW'(SPR_W - 1)) >>> TILE_LOG2) : (w_wx >>> TILE_LOG2);
    assign w_ylead = r_ypos ? ((r_yn + CW'(SPR_H - 1)) >>> TILE_LOG2) : (r_yn >>> TILE_LOG2);
    assign w_xsrc  = (r_state == S_XRES) ? w_x_res : signed'(CW'(X_Out));
    assign w_unused = ^{map_data[DATA_W-1:1], w_lin[31:11], w_y_res[CW-1:10]};

    // State sequencing; probe states last one cycle per address plus one for the final data.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_NETV; else w_state_nxt = S_IDLE;
            S_NETV:   if (r_xmove) w_state_nxt = S_XPROBE; else w_state_nxt = S_XRES;
            S_XPROBE: if (r_cnt == PX_END) w_state_nxt = S_XRES; else w_state_nxt = S_XPROBE;
            S_XRES:   if (r_ymove) w_state_nxt = S_YPROBE; else w_state_nxt = S_YRES;
            S_YPROBE: if (r_cnt == PY_END) w_state_nxt = S_YRES; else w_state_nxt = S_YPROBE;
            S_YRES:   w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Next probe address: leading-edge line crossed with the box span, clipped to its last tile.
    always_comb begin
        if (w_probe) w_k = r_cnt + 8'd1;
        else         w_k = 8'd0;
        if (r_state == S_NETV || r_state == S_XPROBE) begin
            w_lead = w_xlead;
            w_base = signed'(CW'(r_y)) >>> TILE_LOG2;
            w_last = (signed'(CW'(r_y)) + CW'(SPR_H - 1)) >>> TILE_LOG2;
        end else begin
            w_lead = w_ylead;
            w_base = (w_xsrc + w_scroll) >>> TILE_LOG2;
            w_last = (w_xsrc + w_scroll + CW'(SPR_W - 1)) >>> TILE_LOG2;
        end
        w_idx = w_base + signed'(CW'(w_k));
        if (w_idx > w_last) w_idx = w_last;
        else                w_idx = w_idx;
        if (r_state == S_NETV || r_state == S_XPROBE) begin
            w_row = w_idx;
            w_col = w_lead;
        end else begin
            w_row = w_lead;
            w_col = w_idx;
        end
        w_oob = w_row[CW-1] | w_col[CW-1] | (w_row >= CW'(MAP_ROWS)) | (w_col >= CW'(MAP_COLS));
        w_lin = 32'(w_row) * MAP_COLS + 32'(w_col);
    end

    // X resolution; leaving the screen to the left overrides any tile result.
    always_comb begin
        w_x_res = r_xn;
        w_hl    = 1'b0;
        w_hr    = 1'b0;
        if (!r_xmove) begin
            w_x_res = r_xn;
        end else if (r_xpos) begin
            if (r_solid) begin
                w_x_res = (w_xlead <<< TILE_LOG2) - w_scroll - CW'(SPR_W);
                w_hr    = 1'b1;
            end else begin
                w_x_res = r_xn;
            end
        end else if (r_xn[CW-1]) begin
            w_x_res = {CW{1'b0}};
            w_hl    = 1'b1;
        end else if (r_solid) begin
            w_x_res = ((w_xlead + CW'(1)) <<< TILE_LOG2) - w_scroll;
            w_hl    = 1'b1;
        end else begin
            w_x_res = r_xn;
        end
    end

    // Y resolution, same rules in screen rows.
    always_comb begin
        w_y_res = r_yn;
        w_hu    = 1'b0;
        w_hd    = 1'b0;
        if (!r_ymove) begin
            w_y_res = r_yn;
        end else if (r_ypos) begin
            if (r_solid) begin
                w_y_res = (w_ylead <<< TILE_LOG2) - CW'(SPR_H);
                w_hd    = 1'b1;
            end else begin
                w_y_res = r_yn;
            end
        end else if (r_yn[CW-1]) begin
            w_y_res = {CW{1'b0}};
            w_hu    = 1'b1;
        end else if (r_solid) begin
            w_y_res = (w_ylead + CW'(1)) <<< TILE_LOG2;
            w_hu    = 1'b1;
        end else begin
            w_y_res = r_yn;
        end
    end

    // Request capture: velocities are folded into target positions at the start edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_xn <= {CW{1'b0}};  r_yn <= {CW{1'b0}};  r_y <= 10'd0;
            r_xmove <= 1'b0; r_xpos <= 1'b0; r_ymove <= 1'b0; r_ypos <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_xn    <= f_move(X_Pos, Right_V, Left_V);
            r_yn    <= f_move(Y_Pos, Down_V, Up_V);
            r_y     <= Y_Pos;
            r_xmove <= (Right_V != Left_V);
            r_xpos  <= (Right_V > Left_V);
            r_ymove <= (Down_V != Up_V);
            r_ypos  <= (Down_V > Up_V);
        end else begin
            r_xn <= r_xn;  r_yn <= r_yn;  r_y <= r_y;
            r_xmove <= r_xmove; r_xpos <= r_xpos; r_ymove <= r_ymove; r_ypos <= r_ypos;
        end
    end

    // FSM, probe bookkeeping and registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= S_IDLE;  r_cnt <= 8'd0;
            busy      <= 1'b0;    done  <= 1'b0;
            map_addr  <= 11'd0;   r_oob_cur <= 1'b0; r_oob_prv <= 1'b0; r_solid <= 1'b0;
            X_Out     <= 10'd0;   Y_Out <= 10'd0;
            hit_left  <= 1'b0;    hit_right <= 1'b0; hit_up <= 1'b0; hit_down <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            busy    <= (w_state_nxt != S_IDLE);
            done    <= (w_state_nxt == S_DONE);
            if (w_probe && w_state_nxt == r_state) r_cnt <= r_cnt + 8'd1;
            else                                   r_cnt <= 8'd0;
            if (w_load) begin
                map_addr  <= w_lin[10:0];
                r_oob_cur <= w_oob;
            end else begin
                map_addr  <= map_addr;
                r_oob_cur <= r_oob_cur;
            end
            r_oob_prv <= r_oob_cur;
            if (r_state == S_NETV || r_state == S_XRES) r_solid <= 1'b0;
            else if (w_probe && r_cnt != 8'd0)           r_solid <= r_solid | r_oob_prv | ~map_data[0];
            else                                         r_solid <= r_solid;
            if (r_state == S_XRES) begin
                X_Out <= w_x_res[9:0];  hit_left <= w_hl;  hit_right <= w_hr;
            end else begin
                X_Out <= X_Out;         hit_left <= hit_left; hit_right <= hit_right;
            end
            if (r_state == S_YRES) begin
                Y_Out <= w_y_res[9:0];  hit_up <= w_hu;  hit_down <= w_hd;
            end else begin
                Y_Out <= Y_Out;         hit_up <= hit_up; hit_down <= hit_down;
            end
        end
    end
endmodule

// File: tb/tb_collision_resolver.sv
// Randomized self-checking bench for collision_resolver (default build, 40x30 map, 16x16 box).
module tb_collision_resolver;
    localparam int COLS = 40;
    localparam int ROWS = 30;
    localparam int TILE = 16;
    localparam int BOX  = 16;
    localparam int P    = BOX / TILE + 1;

    logic       Clk, Reset_n, start;
    logic [9:0] X_Pos, Y_Pos;
    logic [5:0] Right_V, Left_V, Up_V, Down_V;
    logic [10:0] map_addr;
    logic [4:0] map_data;
    logic       busy, done;
    logic [9:0] X_Out, Y_Out;
    logic       hit_left, hit_right, hit_up, hit_down;

    int errors = 0;
    int checks = 0;
    bit solid_map [0:ROWS-1][0:COLS-1];
    logic [4:0] mem [0:2047];

    collision_resolver dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .busy(busy), .done(done),
        .X_Pos(X_Pos), .Y_Pos(Y_Pos), .Right_V(Right_V), .Left_V(Left_V),
        .Up_V(Up_V), .Down_V(Down_V), .map_addr(map_addr), .map_data(map_data),
        .X_Out(X_Out), .Y_Out(Y_Out), .hit_left(hit_left), .hit_right(hit_right),
        .hit_up(hit_up), .hit_down(hit_down)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Tile memory with one cycle of read latency.
    always @(posedge Clk) map_data <= mem[map_addr];

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Fill memory from the solidity map; bit 0 low marks a solid tile, upper bits are noise.
    task automatic build_mem();
        for (int a = 0; a < 2048; a++) begin
            if (a < ROWS * COLS) mem[a] = {4'($urandom), ~solid_map[a / COLS][a % COLS]};
            else                 mem[a] = 5'($urandom);
        end
    endtask

    task automatic map_fill(input int mode, input int idx);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                case (mode)
                    0: solid_map[r][c] = 1'b0;
                    1: solid_map[r][c] = (r == idx);
                    2: solid_map[r][c] = (c == idx);
                    default: solid_map[r][c] = ($urandom_range(0, 3) == 0);
                endcase
        build_mem();
    endtask

    function automatic bit is_solid(input int r, input int c);
        if (r < 0 || c < 0 || r >= ROWS || c >= COLS) return 1'b1;
        return solid_map[r][c];
    endfunction

    function automatic int clamp_v(input int v);
        if (v > TILE - 1) return TILE - 1;
        if (v < -(TILE - 1)) return -(TILE - 1);
        return v;
    endfunction

    // Reference: move each axis, look at every tile the leading edge line touches, clamp.
    task automatic model(input int x, y, rv, lv, uv, dv, output int xo, yo, fl, lat);
        int dx, dy, xn, yn, lc, lr;
        bit hit, hl, hr, hu, hd;
        dx = clamp_v(rv - lv);  dy = clamp_v(dv - uv);
        xn = x + dx;  yn = y + dy;
        hl = 0; hr = 0; hu = 0; hd = 0;
        xo = x;
        if (dx != 0) begin
            lc = (dx > 0) ? (xn + BOX - 1) / TILE : xn / TILE;
            hit = 0;
            for (int r = y / TILE; r <= (y + BOX - 1) / TILE; r++) hit |= is_solid(r, lc);
            if (dx < 0 && xn < 0) begin xo = 0; hl = 1; end
            else if (hit && dx > 0) begin xo = lc * TILE - BOX; hr = 1; end
            else if (hit) begin xo = (lc + 1) * TILE; hl = 1; end
            else xo = xn;
        end
        yo = y;
        if (dy != 0) begin
            lr = (dy > 0) ? (yn + BOX - 1) / TILE : yn / TILE;
            hit = 0;
            for (int c = xo / TILE; c <= (xo + BOX - 1) / TILE; c++) hit |= is_solid(lr, c);
            if (dy < 0 && yn < 0) begin yo = 0; hu = 1; end
            else if (hit && dy > 0) begin yo = lr * TILE - BOX; hd = 1; end
            else if (hit) begin yo = (lr + 1) * TILE; hu = 1; end
            else yo = yn;
        end
        fl  = {hl, hr, hu, hd};
        lat = 1 + ((dx != 0) ? P + 2 : 1) + ((dy != 0) ? P + 2 : 1) + 1;
    endtask

    task automatic do_resolve(input string tag, input int x, y, rv, lv, uv, dv, input bit glitch);
        int exo, eyo, efl, elat, cyc;
        bit busy_ok;
        model(x, y, rv, lv, uv, dv, exo, eyo, efl, elat);
        @(negedge Clk);
        X_Pos = 10'(x); Y_Pos = 10'(y);
        Right_V = 6'(rv); Left_V = 6'(lv); Up_V = 6'(uv); Down_V = 6'(dv);
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0; cyc = 1; busy_ok = 1'b1;
        while (!done && cyc < 40) begin
            if (!busy) busy_ok = 1'b0;
            if (glitch && cyc == 2) begin
                start = 1'b1; X_Pos = 10'($urandom); Y_Pos = 10'($urandom);
                Right_V = 6'($urandom); Up_V = 6'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge Clk); #1;
            cyc++;
        end
        start = 1'b0;
        check_val({tag, " latency"}, cyc, elat);
        check_val({tag, " busy"}, int'(busy_ok && busy), 1);
        check_val({tag, " X_Out"}, int'(X_Out), exo);
        check_val({tag, " Y_Out"}, int'(Y_Out), eyo);
        check_val({tag, " flags"}, int'({hit_left, hit_right, hit_up, hit_down}), efl);
        @(posedge Clk); #1;
        check_val({tag, " done_pulse"}, int'({done, busy}), 0);
        X_Pos = 10'($urandom); Y_Pos = 10'($urandom); Right_V = 6'($urandom); Down_V = 6'($urandom);
        repeat (2) @(posedge Clk);
        #1;
        check_val({tag, " hold"}, int'({X_Out, Y_Out}), (exo << 10) | eyo);
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, " busy"}, int'(busy), 0);
        check_val({tag, " done"}, int'(done), 0);
        check_val({tag, " X_Out"}, int'(X_Out), 0);
        check_val({tag, " Y_Out"}, int'(Y_Out), 0);
        check_val({tag, " flags"}, int'({hit_left, hit_right, hit_up, hit_down}), 0);
        check_val({tag, " map_addr"}, int'(map_addr), 0);
    endtask

    initial begin
        int x, y, rv, lv, uv, dv;
        Reset_n = 1'b0; start = 1'b0;
        X_Pos = 10'd0; Y_Pos = 10'd0;
        Right_V = 6'd0; Left_V = 6'd0; Up_V = 6'd0; Down_V = 6'd0;
        map_fill(0, 0);
        repeat (3) @(posedge Clk);
        #1;
        check_zero("reset");
        @(negedge Clk); Reset_n = 1'b1;

        do_resolve("open_still", 100, 100, 0, 0, 0, 0, 1'b0);
        map_fill(1, 20);
        do_resolve("row20_down", 64, 300, 0, 0, 0, 8, 1'b0);
        map_fill(2, 10);
        do_resolve("col10_right", 140, 100, 10, 0, 0, 0, 1'b0);
        map_fill(0, 0);
        do_resolve("right_clamp", 200, 50, 63, 0, 0, 0, 1'b0);

        // Reset asserted while the X probe is running.
        @(negedge Clk);
        X_Pos = 10'd100; Y_Pos = 10'd100; Right_V = 6'd5; Left_V = 6'd0; Up_V = 6'd0; Down_V = 6'd0;
        start = 1'b1;
        @(posedge Clk); #1; start = 1'b0;
        @(posedge Clk); #1;
        check_val("mid busy", int'(busy), 1);
        Reset_n = 1'b0;
        #1;
        check_zero("mid_reset");
        @(negedge Clk); Reset_n = 1'b1;
        do_resolve("after_reset", 100, 100, 5, 0, 0, 3, 1'b0);

        do_resolve("left_edge", 3, 50, 0, 10, 0, 0, 1'b0);
        do_resolve("top_edge", 50, 4, 0, 0, 9, 0, 1'b1);
        do_resolve("map_right", 620, 100, 40, 0, 0, 0, 1'b0);
        do_resolve("map_bottom", 100, 465, 0, 0, 0, 30, 1'b0);

        for (int i = 0; i < 120; i++) begin
            if (i % 10 == 0) map_fill(3, 0);
            x  = $urandom_range(0, 630);
            y  = $urandom_range(0, 470);
            rv = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 63);
            lv = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 63);
            uv = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 63);
            dv = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 63);
            do_resolve($sformatf("rand%0d", i), x, y, rv, lv, uv, dv, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
